// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and helpers for the load/store unit
package lsu_pkg;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;

  function automatic logic [3:0] size_bytes(size_e size);
    case (size)
      SZ_B:    return 4'd1;
      SZ_H:    return 4'd2;
      SZ_W:    return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/lsu_data_align.sv
// rtl/lsu_data_align.sv - store-line merge and load-data extension
module lsu_data_align
  import lsu_pkg::*;
(
  input  size_e       size,
  input  logic        is_unsigned,
  input  logic [63:0] line,
  input  logic [63:0] wdata,
  output logic [63:0] store_line,
  output logic [63:0] load_data
);

  logic sign_b, sign_h, sign_w;

  assign sign_b = ~is_unsigned & line[7];
  assign sign_h = ~is_unsigned & line[15];
  assign sign_w = ~is_unsigned & line[31];

  // Low N bytes come from the store data, the rest keep the fetched line.
  always_comb begin
    store_line = line;
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < size_bytes(size)) store_line[8*i +: 8] = wdata[8*i +: 8];
    end
  end

  always_comb begin
    load_data = line;
    case (size)
      SZ_B:    load_data = {{56{sign_b}}, line[7:0]};
      SZ_H:    load_data = {{48{sign_h}}, line[15:0]};
      SZ_W:    load_data = {{32{sign_w}}, line[31:0]};
      default: load_data = line;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-stage load/store unit with read-modify-write stores
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic [63:0] mem_adr,
  output logic [63:0] mem_datain,
  output logic        mem_w,
  output logic        mem_r,
  input  logic [63:0] mem_dataout
);

  localparam logic [63:0] LAST_ADDR = 64'(MEM_BYTES - 8);

  state_e      state_q, state_d;
  logic        we_q, uns_q, err_q;
  size_e       size_q;
  logic [63:0] addr_q, wdata_q, line_q;
  logic [63:0] store_line, load_data;
  logic        accept, req_err;

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid & req_ready;
  assign req_err   = (req_addr > LAST_ADDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= SZ_B;
      addr_q  <= '0;
      wdata_q <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        err_q   <= req_err;
        size_q  <= size_e'(req_size);
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      // Memory output is only meaningful while mem_r is driven.
      if (state_q == READ) line_q <= mem_dataout;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err)                          state_d = RESP;
          else if (req_we && req_size == 2'b11) state_d = WRITE;
          else                                  state_d = READ;
        end
      end
      READ:    state_d = we_q ? WRITE : RESP;
      WRITE:   state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  lsu_data_align u_align (
    .size        (size_q),
    .is_unsigned (uns_q),
    .line        (line_q),
    .wdata       (wdata_q),
    .store_line  (store_line),
    .load_data   (load_data)
  );

  assign mem_adr    = addr_q;
  assign mem_r      = (state_q == READ);
  assign mem_w      = (state_q == WRITE);
  assign mem_datain = mem_w ? store_line : '0;
  assign resp_valid = (state_q == RESP);
  assign resp_err   = resp_valid & err_q;
  assign resp_rdata = (resp_valid && !we_q && !err_q) ? load_data : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed scoreboard bench for load_store_unit
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err, mem_w, mem_r;
  logic [63:0] resp_rdata, mem_adr, mem_datain;
  wire  [63:0] mem_dataout;

  load_store_unit #(.MEM_BYTES(256)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_adr(mem_adr), .mem_datain(mem_datain), .mem_w(mem_w), .mem_r(mem_r),
    .mem_dataout(mem_dataout)
  );

  always #5 clk = ~clk;

  // Data memory: byte i preloaded with i, 8-byte combinational read, 8-byte write.
  logic [7:0]  mem [256];
  logic        loaded = 1'b0;
  logic [63:0] rd_line;

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
      loaded <= 1'b1;
    end else if (mem_w) begin
      for (int k = 0; k < 8; k++) mem[8'(mem_adr[7:0] + 8'(k))] <= mem_datain[8*k +: 8];
    end
  end

  always_comb begin
    rd_line = '0;
    for (int k = 0; k < 8; k++) rd_line[8*k +: 8] = mem[8'(mem_adr[7:0] + 8'(k))];
  end

  assign mem_dataout = mem_r ? rd_line : 64'bz;

  int rd_cnt = 0, wr_cnt = 0;
  always @(negedge clk) begin
    if (mem_r === 1'b1) rd_cnt <= rd_cnt + 1;
    if (mem_w === 1'b1) wr_cnt <= wr_cnt + 1;
  end

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge with the unit idle; returns just after the post-response edge.
  task automatic issue(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [63:0] exp_rd, input logic exp_err, input int exp_lat,
                       input int exp_reads, input int exp_writes);
    exp_t e;
    int   cyc, rd0, wr0;
    sb.push_back('{rdata: exp_rd, err: exp_err, lat: exp_lat});
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    check({tag, " ready"}, 64'(req_ready), 64'd1);
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 1;
    while (resp_valid !== 1'b1 && cyc < 8) begin
      @(posedge clk); #1;
      cyc++;
    end
    e = sb.pop_front();
    check({tag, " resp_valid"}, 64'(resp_valid), 64'd1);
    check({tag, " latency"}, 64'(cyc), 64'(e.lat));
    check({tag, " rdata"}, resp_rdata, e.rdata);
    check({tag, " err"}, 64'(resp_err), 64'(e.err));
    @(posedge clk); #1;
    check({tag, " pulse"}, 64'(resp_valid), 64'd0);
    check({tag, " reads"}, 64'(rd_cnt - rd0), 64'(exp_reads));
    check({tag, " writes"}, 64'(wr_cnt - wr0), 64'(exp_writes));
  endtask

  initial begin
    exp_t e;
    int   wr0;
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst resp_valid", 64'(resp_valid), 64'd0);
    check("rst resp_err", 64'(resp_err), 64'd0);
    check("rst resp_rdata", resp_rdata, 64'd0);
    check("rst mem_r", 64'(mem_r), 64'd0);
    check("rst mem_w", 64'(mem_w), 64'd0);
    check("rst mem_adr", mem_adr, 64'd0);
    check("rst mem_datain", mem_datain, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    issue("LB80",  1'b0, 2'b00, 1'b0, 64'h80, 64'h0, 64'hFFFFFFFFFFFFFF80, 1'b0, 2, 1, 0);
    issue("LBU80", 1'b0, 2'b00, 1'b1, 64'h80, 64'h0, 64'h0000000000000080, 1'b0, 2, 1, 0);
    issue("LD10",  1'b0, 2'b11, 1'b0, 64'h10, 64'h0, 64'h1716151413121110, 1'b0, 2, 1, 0);
    issue("SH20",  1'b1, 2'b01, 1'b0, 64'h20, 64'h000000000000ABCD, 64'h0, 1'b0, 3, 1, 1);
    issue("LD20",  1'b0, 2'b11, 1'b0, 64'h20, 64'h0, 64'h272625242322ABCD, 1'b0, 2, 1, 0);
    issue("LW20",  1'b0, 2'b10, 1'b0, 64'h20, 64'h0, 64'h000000002322ABCD, 1'b0, 2, 1, 0);
    issue("SW30",  1'b1, 2'b10, 1'b0, 64'h30, 64'hFFFF0000DEADBEEF, 64'h0, 1'b0, 3, 1, 1);
    issue("LD30",  1'b0, 2'b11, 1'b0, 64'h30, 64'h0, 64'h37363534DEADBEEF, 1'b0, 2, 1, 0);
    issue("LH32",  1'b0, 2'b01, 1'b0, 64'h32, 64'h0, 64'hFFFFFFFFFFFFDEAD, 1'b0, 2, 1, 0);
    issue("LHU32", 1'b0, 2'b01, 1'b1, 64'h32, 64'h0, 64'h000000000000DEAD, 1'b0, 2, 1, 0);
    issue("SB81",  1'b1, 2'b00, 1'b0, 64'h81, 64'h123456789ABCDE5A, 64'h0, 1'b0, 3, 1, 1);
    issue("LD80",  1'b0, 2'b11, 1'b0, 64'h80, 64'h0, 64'h8786858483825A80, 1'b0, 2, 1, 0);
    issue("LW84",  1'b0, 2'b10, 1'b0, 64'h84, 64'h0, 64'hFFFFFFFF87868584, 1'b0, 2, 1, 0);
    issue("SD08",  1'b1, 2'b11, 1'b0, 64'h08, 64'h0123456789ABCDEF, 64'h0, 1'b0, 2, 0, 1);
    issue("LD08",  1'b0, 2'b11, 1'b0, 64'h08, 64'h0, 64'h0123456789ABCDEF, 1'b0, 2, 1, 0);
    issue("ERRF9", 1'b0, 2'b11, 1'b0, 64'hF9, 64'h0, 64'h0, 1'b1, 1, 0, 0);
    issue("SERRF9", 1'b1, 2'b00, 1'b0, 64'hF9, 64'h55, 64'h0, 1'b1, 1, 0, 0);
    issue("LDF8",  1'b0, 2'b11, 1'b0, 64'hF8, 64'h0, 64'hFFFEFDFCFBFAF9F8, 1'b0, 2, 1, 0);
    issue("ERR4G", 1'b0, 2'b00, 1'b0, 64'h1_0000_0000, 64'h0, 64'h0, 1'b1, 1, 0, 0);

    // Reset asserted in the WRITE cycle of a double store aborts it with no write.
    wr0 = wr_cnt;
    req_we = 1'b1; req_size = 2'b11; req_unsigned = 1'b0;
    req_addr = 64'h40; req_wdata = 64'h1122334455667788;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rstw mem_w before", 64'(mem_w), 64'd1);
    rst = 1'b1;
    #1;
    check("rstw mem_w dropped", 64'(mem_w), 64'd0);
    check("rstw resp_valid", 64'(resp_valid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rstw ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    check("rstw no resp", 64'(resp_valid), 64'd0);
    check("rstw writes", 64'(wr_cnt - wr0), 64'd0);
    issue("LD40",  1'b0, 2'b11, 1'b0, 64'h40, 64'h0, 64'h4746454443424140, 1'b0, 2, 1, 0);

    // Back-to-back loads with req_valid held high throughout.
    sb.push_back('{rdata: 64'h1716151413121110, err: 1'b0, lat: 2});
    sb.push_back('{rdata: 64'h1F1E1D1C1B1A1918, err: 1'b0, lat: 5});
    req_we = 1'b0; req_size = 2'b11; req_unsigned = 1'b0; req_addr = 64'h10;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_addr = 64'h18;
    check("b2b ready c1", 64'(req_ready), 64'd0);
    check("b2b resp c1", 64'(resp_valid), 64'd0);
    @(posedge clk); #1;
    e = sb.pop_front();
    check("b2b ready c2", 64'(req_ready), 64'd0);
    check("b2b resp c2", 64'(resp_valid), 64'd1);
    check("b2b rdata1", resp_rdata, e.rdata);
    @(posedge clk); #1;
    check("b2b resp c3", 64'(resp_valid), 64'd0);
    check("b2b ready c3", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("b2b accepted c4", 64'(req_ready), 64'd0);
    check("b2b mem_r c4", 64'(mem_r), 64'd1);
    @(posedge clk); #1;
    e = sb.pop_front();
    check("b2b resp c5", 64'(resp_valid), 64'd1);
    check("b2b rdata2", resp_rdata, e.rdata);
    @(posedge clk); #1;
    check("b2b resp c6", 64'(resp_valid), 64'd0);
    check("b2b ready c6", 64'(req_ready), 64'd1);
    check("scoreboard empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit between the execute stage and the 256-byte, byte-addressed, little-endian data memory. It accepts one load or store per valid/ready handshake and supports byte, half, word and double sizes. Loads are sign- or zero-extended. Sub-doubleword stores use a read-modify-write sequence because the data memory always writes 8 bytes. Out-of-range requests are rejected without touching memory.

## Interface

Parameters:
- MEM_BYTES, 256, size of data memory in bytes.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset. Asynchronous, active-high; one clock domain.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  access size: 00 byte, 01 half, 10 word, 11 double.
- req_unsigned  in  1  load zero-extends when 1; ignored for stores.
- req_addr  in  64  byte address.
- req_wdata  in  64  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  64  extended load data; 0 for stores and errors.
- resp_err  out  1  request rejected (address out of range); valid with resp_valid.
- mem_adr  out  64  data memory address.
- mem_datain  out  64  data memory write data.
- mem_w  out  1  data memory write enable.
- mem_r  out  1  data memory read enable.
- mem_dataout  in  64  data memory read data; combinational, high-Z when mem_r = 0.

## Operation

- **Handshake:** a request is accepted on a rising edge with req_valid & req_ready. req_ready = 1 only in IDLE. All request fields are captured at acceptance. No backpressure on the response.
- **Error rule:** every access touches 8 bytes. resp_err = 1 when req_addr > MEM_BYTES-8, compared on the full 64 bits. Error requests go IDLE -> RESP and never assert mem_r or mem_w.
- **States:** IDLE, READ, WRITE, RESP.
  - Load: IDLE -> READ -> RESP.
  - Store double: IDLE -> WRITE -> RESP.
  - Store byte/half/word: IDLE -> READ -> WRITE -> RESP.
  - RESP -> IDLE always.
- **READ:**
  - mem_r = 1, mem_adr = captured addr.
  - mem_dataout is registered into a 64-bit line buffer at the end of the cycle.
  - mem_dataout is sampled only in READ.
- **WRITE:**
  - mem_w = 1, mem_adr = captured addr.
  - mem_datain = the line buffer with its low N bytes replaced by the low N bytes of wdata. N = 1/2/4; for double, mem_datain = wdata.
- **RESP:**
  - resp_valid = 1.
  - For loads, resp_rdata = the low N bytes of the line buffer, extended to 64 bits. The extension is zero when req_unsigned = 1, otherwise sign from bit 8N-1.
- **Idle outputs:**
  - mem_r = mem_w = 0 outside READ/WRITE.
  - mem_datain = 0 outside WRITE.
  - mem_adr holds the captured address.
- **Reset:** asynchronous.
  - State -> IDLE; line buffer, captured fields and mem_adr -> 0.
  - resp_valid = 0, resp_err = 0, resp_rdata = 0, mem_w = 0, mem_r = 0, mem_datain = 0.
  - req_ready = 1 once rst deasserts; no request is accepted while rst = 1.
  - Reset during WRITE drops mem_w immediately, so no memory write occurs. Reset in any state aborts the access with no response.

## Timing

- Acceptance edge = cycle 0. resp_valid is high in:
  - cycle 1 for errors;
  - cycle 2 for loads and double stores;
  - cycle 3 for sub-double stores.
- Next acceptance is possible on the edge ending the RESP cycle + 1, i.e. after a cycle in IDLE. Minimum issue interval: 3 cycles (load), 4 cycles (sub-double store).
- The memory write commits on the rising edge that ends the WRITE cycle.
- All outputs are decoded from registered state and captured fields. There is no combinational path from req_* to outputs, except req_ready, which depends on state only.

## Structure

- **Package lsu_pkg:**
  - size enum: SZ_B, SZ_H, SZ_W, SZ_D;
  - state enum: IDLE, READ, WRITE, RESP;
  - function size_bytes(size) returns 1/2/4/8.
- **Sub-module lsu_data_align** (combinational):
  - inputs: size, unsigned, line, wdata;
  - outputs: merged store line and extended load data.
- The top level holds the FSM, the capture registers and the line buffer.

## Test plan

The bench instantiates the team data memory, preloaded with byte i = i.
- **Load byte:** LB at 0x80 signed -> resp_rdata = 0xFFFFFFFFFFFFFF80 in cycle 2. LBU at 0x80 -> 0x0000000000000080.
- **Load double:** LD at 0x10 -> 0x1716151413121110; mem_r high for exactly 1 cycle; mem_w is never asserted.
- **Sub-double store:** SH 0x000000000000ABCD at 0x20 -> resp in cycle 3. A following LD at 0x20 -> 0x272625242322ABCD. LW signed at 0x20 -> 0x000000002322ABCD.
- **Address bounds:**
  - addr 0xF9 -> resp_err = 1 in cycle 1, resp_rdata = 0, no mem_r/mem_w.
  - addr 0xF8 LD -> 0xFFFEFDFCFBFAF9F8, no error.
  - addr 0x1_0000_0000 -> resp_err = 1.
- **Reset during WRITE:** assert rst during the WRITE cycle of SD 0x1122334455667788 at 0x40. LD 0x40 afterwards returns 0x4746454443424140; req_ready = 1 after reset release.
- **Back-to-back requests:** hold req_valid for two loads. req_ready stays low from cycle 1 to cycle 2; the second request is accepted one cycle after the first response; each resp_valid pulse is exactly 1 cycle.
